// File: rtl/seg7_scan_driver_if.sv
// Display-value bus between the CPU-side producer and the seven-segment scan driver.
// The producer drives the value, brightness and blank request; the driver returns the pin pattern.
interface seg7_scan_driver_if #(
  parameter int PWM_WIDTH = 4
);
  logic [7:0]           din;
  logic [PWM_WIDTH-1:0] brightness;
  logic                 blank;
  logic [7:0]           dout;

  modport master (output din, brightness, blank, input dout);
  modport slave  (input din, brightness, blank, output dout);
endinterface

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed hex display driver: frame-synchronous input latch, brightness PWM,
// leading-zero blanking and dead time at the start of every digit slot.
module seg7_scan_driver #(
  parameter int DIV_WIDTH = 10,
  parameter int PWM_WIDTH = 4,
  parameter int DEAD      = 4,
  parameter bit BLANK_LZ  = 1'b1
) (
  input logic               CLK,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  if (DIV_WIDTH < PWM_WIDTH + 3) begin : g_bad_div
    $error("DIV_WIDTH must be at least PWM_WIDTH+3");
  end
  if (DEAD >= (1 << (DIV_WIDTH - PWM_WIDTH))) begin : g_bad_dead
    $error("DEAD must be shorter than one PWM step");
  end

  localparam logic [DIV_WIDTH-1:0] DEAD_CNT = DIV_WIDTH'(DEAD);

  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 digit_sel;
  logic [7:0]           shadow_val;
  logic [PWM_WIDTH-1:0] shadow_bri;
  logic                 shadow_blank;

  logic                 slot_end;
  logic                 frame_end;
  logic [3:0]           nibble;
  logic [6:0]           seg_hi;
  logic                 seg_en;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  assign slot_end  = (div_cnt == '1);
  assign frame_end = slot_end && digit_sel;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // holding a stale value and no latch is inferred.
  always_comb begin
    nibble = shadow_val[3:0];
    seg_en = 1'b1;
    if (digit_sel) nibble = shadow_val[7:4];
    seg_hi = hex_to_seg(nibble);
    if (div_cnt < DEAD_CNT)                              seg_en = 1'b0;
    if (div_cnt[DIV_WIDTH-1 -: PWM_WIDTH] > shadow_bri)  seg_en = 1'b0;
    if (shadow_blank)                                    seg_en = 1'b0;
    if (BLANK_LZ && digit_sel && shadow_val[7:4] == 4'h0) seg_en = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_sel <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (slot_end) digit_sel <= ~digit_sel;
    end
  end

  // Shadows only move on the last clock of slot 1, so a frame never mixes two input values.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      shadow_val   <= 8'h00;
      shadow_bri   <= '0;
      shadow_blank <= 1'b1;
    end else if (frame_end) begin
      shadow_val   <= bus.din;
      shadow_bri   <= bus.brightness;
      shadow_blank <= bus.blank;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) bus.dout <= 8'h7F;
    else     bus.dout <= {digit_sel, seg_en ? ~seg_hi : 7'h7F};
  end

endmodule
